// File: rtl/control_flow_unit_pipe.sv
// control_flow_unit_pipe: elastic, multi-stage control-flow execute unit.
// Resolves JAL/JALR and the six RV32 conditional branches when an op is accepted
// from D. The outcome travels down the pipe to W, where a redirecting op raises
// the squash notification. Any squash, whether from this unit or from another,
// kills the younger ops still in flight here.
//
// D_uop encoding: 0 JAL, 1 JALR, 2 BEQ, 3 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
//
// Optional feature, macro CFU_PRED_CHECK_EN: the op's resolved next PC is compared
// with D_pred_tgt. Only a mismatch squashes, and the squash target is the actual
// next PC. A mispredict counter, mispred_cnt, is also added.
module control_flow_unit_pipe #(
  parameter int p_seq_num_bits = 5,
  parameter int p_num_stages   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      D_val,
  output logic                      D_rdy,
  input  logic [31:0]               D_pc,
  input  logic [p_seq_num_bits-1:0] D_seq_num,
  input  logic [31:0]               D_op1,
  input  logic [31:0]               D_op2,
  input  logic [31:0]               D_op3,
  input  logic [4:0]                D_waddr,
  input  logic [2:0]                D_uop,
`ifdef CFU_PRED_CHECK_EN
  input  logic [31:0]               D_pred_tgt,
  output logic [31:0]               mispred_cnt,
`endif
  output logic                      W_val,
  input  logic                      W_rdy,
  output logic [31:0]               W_pc,
  output logic [p_seq_num_bits-1:0] W_seq_num,
  output logic [4:0]                W_waddr,
  output logic [31:0]               W_wdata,
  output logic                      W_wen,
  input  logic                      sq_in_val,
  input  logic [p_seq_num_bits-1:0] sq_in_seq_num,
  output logic                      squash_val,
  output logic [p_seq_num_bits-1:0] squash_seq_num,
  output logic [31:0]               squash_target
);

  localparam int SN   = p_seq_num_bits;
  localparam int LAST = p_num_stages - 1;

  localparam logic [2:0] UOP_JAL  = 3'd0;
  localparam logic [2:0] UOP_JALR = 3'd1;
  localparam logic [2:0] UOP_BEQ  = 3'd2;
  localparam logic [2:0] UOP_BNE  = 3'd3;
  localparam logic [2:0] UOP_BLT  = 3'd4;
  localparam logic [2:0] UOP_BGE  = 3'd5;
  localparam logic [2:0] UOP_BLTU = 3'd6;
  localparam logic [2:0] UOP_BGEU = 3'd7;

  typedef struct packed {
    logic [31:0]   pc;
    logic [SN-1:0] seq;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          wen;
    logic [31:0]   tgt;
    logic          redir;
  } stage_t;

  stage_t          st [p_num_stages];
  logic [LAST:0]   st_val;
  logic [LAST:0]   free;
  logic [LAST:0]   kill;
  logic            kill_d;
  logic            w_xfer;
  logic            last_kill_ext;
  stage_t          res;
  logic [31:0]     pc4;
  logic [31:0]     br_tgt;
  logic [31:0]     jr_sum;

  // a is younger than b when (a - b) mod 2^SN lies in [1, 2^(SN-1)).
  function automatic logic younger(input logic [SN-1:0] a, input logic [SN-1:0] b);
    logic [SN-1:0] d;
    d = a - b;
    return (d != '0) && !d[SN-1];
  endfunction

  assign pc4    = D_pc + 32'd4;
  assign br_tgt = D_pc + D_op3;
  assign jr_sum = D_op1 + D_op3;

  // Resolve the incoming op so that only the outcome has to be carried down the pipe.
  always_comb begin
    logic redir;
    logic taken;
    logic [31:0] tgt;
`ifdef CFU_PRED_CHECK_EN
    logic [31:0] actual;
`endif
    res       = '0;
    res.pc    = D_pc;
    res.seq   = D_seq_num;
    redir     = 1'b0;
    taken     = 1'b0;
    tgt       = br_tgt;
    case (D_uop)
      UOP_JAL: begin
        redir     = 1'b1;
        res.waddr = D_waddr;
        res.wdata = pc4;
        res.wen   = 1'b1;
      end
      UOP_JALR: begin
        redir     = 1'b1;
        tgt       = jr_sum & ~32'd1;
        res.waddr = D_waddr;
        res.wdata = pc4;
        res.wen   = 1'b1;
      end
      UOP_BEQ:  taken = (D_op1 == D_op2);
      UOP_BNE:  taken = (D_op1 != D_op2);
      UOP_BLT:  taken = ($signed(D_op1) <  $signed(D_op2));
      UOP_BGE:  taken = ($signed(D_op1) >= $signed(D_op2));
      UOP_BLTU: taken = (D_op1 <  D_op2);
      UOP_BGEU: taken = (D_op1 >= D_op2);
      default:  taken = 1'b0;
    endcase
    redir = redir || taken;
`ifdef CFU_PRED_CHECK_EN
    actual    = redir ? tgt : pc4;
    res.redir = (actual != D_pred_tgt);
    res.tgt   = actual;
`else
    res.redir = redir;
    res.tgt   = tgt;
`endif
  end

  // The retiring op can only be killed by an external squash; its own squash never covers itself.
  assign last_kill_ext = sq_in_val && younger(st[LAST].seq, sq_in_seq_num);
  assign W_val         = st_val[LAST] && !last_kill_ext;
  assign w_xfer        = W_val && W_rdy;
  assign squash_val    = w_xfer && st[LAST].redir;

  assign W_pc           = st[LAST].pc;
  assign W_seq_num      = st[LAST].seq;
  assign W_waddr        = st[LAST].waddr;
  assign W_wdata        = st[LAST].wdata;
  assign W_wen          = st[LAST].wen;
  assign squash_seq_num = st[LAST].seq;
  assign squash_target  = st[LAST].tgt;

  // A stage can take new contents when it or any stage downstream has a hole, or when the last stage retires.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    free     = '0;
    for (int i = LAST; i >= 0; i--) begin
      all_full = all_full && st_val[i];
      free[i]  = !all_full || w_xfer;
    end
  end

  assign D_rdy = free[0];

  // Kill every stage op, and any op arriving from D, that is younger than an active squash.
  always_comb begin
    kill = '0;
    for (int i = 0; i <= LAST; i++) begin
      kill[i] = (sq_in_val && younger(st[i].seq, sq_in_seq_num)) ||
                (squash_val && younger(st[i].seq, st[LAST].seq));
    end
    kill_d = (sq_in_val && younger(D_seq_num, sq_in_seq_num)) ||
             (squash_val && younger(D_seq_num, st[LAST].seq));
  end

  // Pipeline registers: advance into free stages, and drop killed ops where they stand.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_val <= '0;
      for (int i = 0; i <= LAST; i++) st[i] <= '0;
    end else begin
      for (int i = LAST; i >= 1; i--) begin
        if (free[i]) begin
          st_val[i] <= st_val[i-1] && !kill[i-1];
          st[i]     <= st[i-1];
        end else begin
          st_val[i] <= st_val[i] && !kill[i];
        end
      end
      if (free[0]) begin
        st_val[0] <= D_val && !kill_d;
        if (D_val) st[0] <= res;
      end else begin
        st_val[0] <= st_val[0] && !kill[0];
      end
    end
  end

`ifdef CFU_PRED_CHECK_EN
  // Count each mispredict squash; the counter wraps at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mispred_cnt <= '0;
    else if (squash_val) mispred_cnt <= mispred_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_control_flow_unit_pipe.sv
// Scoreboard bench for control_flow_unit_pipe (3 stages, 5-bit sequence numbers).
module tb_control_flow_unit_pipe;
  localparam int SN = 5;
  localparam int NS = 3;

  localparam logic [2:0] U_JAL  = 3'd0;
  localparam logic [2:0] U_JALR = 3'd1;
  localparam logic [2:0] U_BEQ  = 3'd2;
  localparam logic [2:0] U_BNE  = 3'd3;
  localparam logic [2:0] U_BLT  = 3'd4;
  localparam logic [2:0] U_BGE  = 3'd5;
  localparam logic [2:0] U_BLTU = 3'd6;
  localparam logic [2:0] U_BGEU = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          D_val = 1'b0;
  logic          D_rdy;
  logic [31:0]   D_pc = '0;
  logic [SN-1:0] D_seq_num = '0;
  logic [31:0]   D_op1 = '0, D_op2 = '0, D_op3 = '0;
  logic [4:0]    D_waddr = '0;
  logic [2:0]    D_uop = '0;
  logic          W_val;
  logic          W_rdy = 1'b1;
  logic [31:0]   W_pc;
  logic [SN-1:0] W_seq_num;
  logic [4:0]    W_waddr;
  logic [31:0]   W_wdata;
  logic          W_wen;
  logic          sq_in_val = 1'b0;
  logic [SN-1:0] sq_in_seq_num = '0;
  logic          squash_val;
  logic [SN-1:0] squash_seq_num;
  logic [31:0]   squash_target;
`ifdef CFU_PRED_CHECK_EN
  logic [31:0]   D_pred_tgt = '0;
  logic [31:0]   mispred_cnt;
`endif

  control_flow_unit_pipe #(.p_seq_num_bits(SN), .p_num_stages(NS)) dut (
    .clk(clk), .rst(rst),
    .D_val(D_val), .D_rdy(D_rdy), .D_pc(D_pc), .D_seq_num(D_seq_num),
    .D_op1(D_op1), .D_op2(D_op2), .D_op3(D_op3), .D_waddr(D_waddr), .D_uop(D_uop),
`ifdef CFU_PRED_CHECK_EN
    .D_pred_tgt(D_pred_tgt), .mispred_cnt(mispred_cnt),
`endif
    .W_val(W_val), .W_rdy(W_rdy), .W_pc(W_pc), .W_seq_num(W_seq_num),
    .W_waddr(W_waddr), .W_wdata(W_wdata), .W_wen(W_wen),
    .sq_in_val(sq_in_val), .sq_in_seq_num(sq_in_seq_num),
    .squash_val(squash_val), .squash_seq_num(squash_seq_num), .squash_target(squash_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  seq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    bit          lat;
    int          issue;
  } w_exp_t;

  typedef struct {
    logic [4:0]  seq;
    logic [31:0] tgt;
  } sq_exp_t;

  w_exp_t  wq[$];
  sq_exp_t sq[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_w(input logic [31:0] pc, input logic [4:0] seq, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic wen, input bit lat, input int issue);
    w_exp_t e;
    e.pc = pc; e.seq = seq; e.waddr = waddr; e.wdata = wdata; e.wen = wen;
    e.lat = lat; e.issue = issue;
    wq.push_back(e);
  endtask

  task automatic push_sq(input logic [4:0] seq, input logic [31:0] tgt);
    sq_exp_t e;
    e.seq = seq; e.tgt = tgt;
    sq.push_back(e);
  endtask

  // Monitor: compare every W transfer and every squash against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (W_val && W_rdy) begin
        if (wq.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_w: got seq %0d pc 0x%08h, expected no transfer", W_seq_num, W_pc);
        end else begin
          w_exp_t e;
          e = wq.pop_front();
          chk("w_pc", W_pc, e.pc);
          chk("w_seq", 32'(W_seq_num), 32'(e.seq));
          chk("w_waddr", 32'(W_waddr), 32'(e.waddr));
          chk("w_wdata", W_wdata, e.wdata);
          chk("w_wen", 32'(W_wen), 32'(e.wen));
          if (e.lat) chk("w_latency", 32'(cyc - e.issue), NS);
        end
      end
      if (squash_val) begin
        chk("squash_on_w_xfer", 32'(W_val && W_rdy), 32'd1);
        if (sq.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_squash: got seq %0d tgt 0x%08h, expected none", squash_seq_num, squash_target);
        end else begin
          sq_exp_t s;
          s = sq.pop_front();
          chk("squash_seq", 32'(squash_seq_num), 32'(s.seq));
          chk("squash_target", squash_target, s.tgt);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] seq, input logic [2:0] uop,
                      input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                      input logic [4:0] waddr, output int issue);
    D_val = 1'b1; D_pc = pc; D_seq_num = seq; D_uop = uop;
    D_op1 = op1; D_op2 = op2; D_op3 = imm; D_waddr = waddr;
    issue = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (D_rdy) begin
        issue = cyc;
        break;
      end
    end
    if (issue < 0) begin
      total_cnt++;
      $display("FAIL send_timeout: got D_rdy low for 50 cycles, expected acceptance of seq %0d", seq);
    end
    @(posedge clk);
    #1;
    D_val = 1'b0;
  endtask

  task automatic op_iso(input logic [31:0] pc, input logic [4:0] seq, input logic [2:0] uop,
                        input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                        input logic [4:0] waddr, input logic [4:0] e_waddr, input logic [31:0] e_wdata,
                        input logic e_wen, input bit e_sq, input logic [31:0] e_tgt);
    int iss;
    send(pc, seq, uop, op1, op2, imm, waddr, iss);
    push_w(pc, seq, e_waddr, e_wdata, e_wen, 1'b1, iss);
    if (e_sq) push_sq(seq, e_tgt);
    idle(NS + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int iss;
    #1 rst = 1'b0;
    #1;
    chk("rst_w_val", 32'(W_val), 32'd0);
    chk("rst_squash_val", 32'(squash_val), 32'd0);
    chk("rst_d_rdy", 32'(D_rdy), 32'd1);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Isolated ops through an empty pipe
    op_iso(32'h100, 5'd3,  U_JAL,  32'd0, 32'd0, 32'h20, 5'd1, 5'd1, 32'h104, 1'b1, 1'b1, 32'h120);
    op_iso(32'h40,  5'd4,  U_BNE,  32'd5, 32'd5, 32'hFFFF_FFF8, 5'd7, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    op_iso(32'h40,  5'd5,  U_BNE,  32'd5, 32'd6, 32'hFFFF_FFF8, 5'd7, 5'd0, 32'd0, 1'b0, 1'b1, 32'h38);
    op_iso(32'h200, 5'd6,  U_JALR, 32'h203, 32'd0, 32'd0, 5'd2, 5'd2, 32'h204, 1'b1, 1'b1, 32'h202);
    op_iso(32'h300, 5'd7,  U_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    op_iso(32'h300, 5'd8,  U_BLT,  32'hFFFF_FFFF, 32'd1, 32'h10, 5'd3, 5'd0, 32'd0, 1'b0, 1'b1, 32'h310);
    op_iso(32'h340, 5'd10, U_BGE,  32'hFFFF_FFFF, 32'd1, 32'h24, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    op_iso(32'h340, 5'd11, U_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h24, 5'd3, 5'd0, 32'd0, 1'b0, 1'b1, 32'h364);
    op_iso(32'h360, 5'd12, U_BEQ,  32'd1, 32'd2, 32'h40, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    op_iso(32'h380, 5'd13, U_JALR, 32'h1000, 32'd0, 32'hFFFF_FFFD, 5'd31, 5'd31, 32'h384, 1'b1, 1'b1, 32'hFFC);

    // Back-to-back: taken BEQ followed by younger JALs; the one arriving in the squash cycle is dropped too
    send(32'h800, 5'd14, U_BEQ, 32'd7, 32'd7, 32'h30, 5'd0, iss);
    push_w(32'h800, 5'd14, 5'd0, 32'd0, 1'b0, 1'b1, iss);
    push_sq(5'd14, 32'h830);
    send(32'h804, 5'd15, U_JAL, 32'd0, 32'd0, 32'h100, 5'd1, iss);
    send(32'h808, 5'd16, U_JAL, 32'd0, 32'd0, 32'h100, 5'd1, iss);
    send(32'h80C, 5'd17, U_JAL, 32'd0, 32'd0, 32'h100, 5'd1, iss);
    idle(NS + 3);
    op_iso(32'h900, 5'd18, U_JAL, 32'd0, 32'd0, 32'h8, 5'd5, 5'd5, 32'h904, 1'b1, 1'b1, 32'h908);

    // Full pipe stalled by W_rdy, then an external squash with sequence wrap-around
    W_rdy = 1'b0;
    send(32'h500, 5'd29, U_BEQ, 32'd1, 32'd2, 32'h10, 5'd0, iss);
    send(32'h504, 5'd31, U_BEQ, 32'd1, 32'd2, 32'h10, 5'd0, iss);
    send(32'h508, 5'd0,  U_BEQ, 32'd1, 32'd2, 32'h10, 5'd0, iss);
    push_w(32'h500, 5'd29, 5'd0, 32'd0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_d_rdy", 32'(D_rdy), 32'd0);
      chk("stall_w_val", 32'(W_val), 32'd1);
      chk("stall_w_seq", 32'(W_seq_num), 32'd29);
      chk("stall_w_pc", W_pc, 32'h500);
    end
    @(posedge clk); #1;
    sq_in_val = 1'b1; sq_in_seq_num = 5'd30;
    @(negedge clk);
    chk("sq_in_older_kept", 32'(W_val), 32'd1);
    @(posedge clk); #1;
    sq_in_val = 1'b0;
    W_rdy = 1'b1;
    idle(NS + 3);

    // Retiring redirect younger than the external squash: killed, no squash
    W_rdy = 1'b0;
    send(32'h600, 5'd20, U_JAL, 32'd0, 32'd0, 32'h40, 5'd3, iss);
    idle(NS);
    sq_in_val = 1'b1; sq_in_seq_num = 5'd19; W_rdy = 1'b1;
    @(negedge clk);
    chk("sim_younger_w_val", 32'(W_val), 32'd0);
    chk("sim_younger_squash", 32'(squash_val), 32'd0);
    @(posedge clk); #1;
    sq_in_val = 1'b0;
    idle(NS + 2);

    // Retiring redirect older than the external squash: both apply
    W_rdy = 1'b0;
    send(32'h700, 5'd20, U_JAL, 32'd0, 32'd0, 32'h10, 5'd4, iss);
    idle(NS);
    push_w(32'h700, 5'd20, 5'd4, 32'h704, 1'b1, 1'b0, 0);
    push_sq(5'd20, 32'h710);
    sq_in_val = 1'b1; sq_in_seq_num = 5'd21; W_rdy = 1'b1;
    @(negedge clk);
    chk("sim_older_squash", 32'(squash_val), 32'd1);
    @(posedge clk); #1;
    sq_in_val = 1'b0;
    idle(NS + 2);

    // Reset in the middle of a stalled redirect
    W_rdy = 1'b0;
    send(32'hA00, 5'd1, U_JAL, 32'd0, 32'd0, 32'h40, 5'd6, iss);
    idle(NS);
    @(negedge clk);
    chk("pre_rst_w_val", 32'(W_val), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_w_val", 32'(W_val), 32'd0);
    chk("mid_rst_squash", 32'(squash_val), 32'd0);
    chk("mid_rst_d_rdy", 32'(D_rdy), 32'd1);
    #7 rst = 1'b1;
    W_rdy = 1'b1;
    idle(NS + 4);

    chk("w_queue_empty", 32'(wq.size()), 32'd0);
    chk("squash_queue_empty", 32'(sq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
